bl_mask_8x32_2: RTL and testbench

//  Bitline-mask generator for the 8-row x 32-column SRAM macro with 2-bit width config.

---
 rtl/bl_mask_8x32_2_pkg.sv | 26 ++
 rtl/bl_mask_8x32_2_if.sv | 28 ++
 rtl/bl_mask_decode.sv | 26 ++
 rtl/bl_mask_8x32_2.sv | 36 +++
 tb/tb_bl_mask_8x32_2.sv | 132 +++++++++++++
 5 files changed

// File: rtl/bl_mask_8x32_2_pkg.sv
// Shared definitions for the 8-row x 32-column bitline-mask block.
//   DATA_W : physical bitline count (mask width), fixed at 32 for this macro
//   ADDR_W : sub-word address width
//   CONF_W : word-width configuration field width
//   conf_e : word-width configuration encodings
package bl_mask_8x32_2_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int CONF_W = 2;

    typedef enum logic [CONF_W-1:0] {
        CONF_W32  = 2'b00,   // full 32-bit word
        CONF_W16  = 2'b01,   // two 16-bit half-words
        CONF_W8   = 2'b10,   // four 8-bit bytes
        CONF_RSVD = 2'b11    // reserved, no bitlines enabled
    } conf_e;

    // Byte-lane mask for lane k: bits [8k+7:8k] set.
    function automatic logic [DATA_W-1:0] byte_lane_mask(input logic [ADDR_W-1:0] k);
        logic [DATA_W-1:0] lane0;
        lane0 = DATA_W'(8'hFF);
        return lane0 << {k, 3'b000};
    endfunction

endpackage

// File: rtl/bl_mask_8x32_2_if.sv
// Bus bundle between the address/config decoder and the bitline-mask block.
//   addr    : sub-word select within the 32-bit row
//   conf    : word-width configuration (conf_e encoding)
//   bl_mask : registered bitline enable mask, 1 = bitline active
// There is no valid/ready handshake: the block samples addr/conf on every
// rising clock edge and presents the decoded mask one cycle later.
interface bl_mask_8x32_2_if;
    import bl_mask_8x32_2_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [CONF_W-1:0] conf;
    logic [DATA_W-1:0] bl_mask;

    // master: the decoder side that supplies addr/conf and consumes the mask
    modport master (
        output addr,
        output conf,
        input  bl_mask
    );

    // slave: the mask generator
    modport slave (
        input  addr,
        input  conf,
        output bl_mask
    );

endinterface

// File: rtl/bl_mask_decode.sv
// Purely combinational (conf, addr) -> bitline mask decoder.
//   conf : word-width configuration
//   addr : sub-word select
//   mask : contiguous, aligned segment of 0, 8, 16 or 32 set bits;
//          segment 0 sits in the LSBs
module bl_mask_decode
    import bl_mask_8x32_2_pkg::*;
(
    input  logic [CONF_W-1:0] conf,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] mask
);

    always_comb begin
        mask = '0;
        case (conf_e'(conf))
            CONF_W32:  mask = '1;
            // addr[1] has no meaning for half-words and is ignored
            CONF_W16:  mask = addr[0] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            CONF_W8:   mask = byte_lane_mask(addr);
            CONF_RSVD: mask = '0;
            default:   mask = '0;
        endcase
    end

endmodule

// File: rtl/bl_mask_8x32_2.sv
// Bitline-mask generator for the 8x32 SRAM macro with 2-bit width config.
// Decodes the word-width configuration and sub-word address into a mask
// that enables only the bitlines of the selected sub-word; the result is
// registered, giving exactly one clock of latency.
//   clk   : single clock, rising-edge active
//   rst_n : synchronous active-low reset, clears the mask
//   bus   : slave side of bl_mask_8x32_2_if (addr, conf in; bl_mask out)
module bl_mask_8x32_2
    import bl_mask_8x32_2_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    bl_mask_8x32_2_if.slave         bus
);

    logic [DATA_W-1:0] mask_d;
    logic [DATA_W-1:0] mask_q;

    bl_mask_decode u_decode (
        .conf (bus.conf),
        .addr (bus.addr),
        .mask (mask_d)
    );

    // Reset wins over the decode result on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign bus.bl_mask = mask_q;

endmodule

// File: tb/tb_bl_mask_8x32_2.sv
module tb_bl_mask_8x32_2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bl_mask_8x32_2_if bus ();

    bl_mask_8x32_2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference: a sub-word of width w = 32 >> conf (reserved -> none),
    // index = addr mod (32/w), occupying bits [idx*w, idx*w+w).
    function automatic logic [31:0] ref_mask(input int conf_v, input int addr_v);
        logic [31:0] m;
        int w;
        int idx;
        m = 32'h0;
        case (conf_v)
            0: w = 32;
            1: w = 16;
            2: w = 8;
            default: w = 0;
        endcase
        if (w != 0) begin
            idx = addr_v % (32 / w);
            for (int b = 0; b < 32; b++) begin
                if (b >= idx * w && b < idx * w + w) m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    // ---------------- driver ----------------
    // Applies inputs after a falling edge; the result is due after the next rising edge.
    task automatic drive(input logic rst_v, input int conf_v, input int addr_v, input string nm);
        @(negedge clk);
        rst_n    = rst_v;
        bus.conf = 2'(conf_v);
        bus.addr = 2'(addr_v);
        exp_q.push_back(rst_v ? ref_mask(conf_v, addr_v) : 32'h0);
        name_q.push_back(nm);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [31:0] exp_v;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                checks++;
                if (bus.bl_mask !== exp_v) begin
                    errors++;
                    $display("FAIL %s: bl_mask=%08h expected=%08h conf=%0d addr=%0d rst_n=%0b",
                             nm, bus.bl_mask, exp_v, bus.conf, bus.addr, rst_n);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cycles;
        logic r;
        int c;
        int a;
        rst_n    = 1'b0;
        bus.conf = 2'b00;
        bus.addr = 2'b00;

        // reset for two edges, then release
        drive(1'b0, 0, 0, "reset0");
        drive(1'b0, 0, 0, "reset1");
        drive(1'b1, 0, 0, "release_w32");

        // directed decode table
        drive(1'b1, 0, 3, "w32_addr3");
        drive(1'b1, 1, 0, "w16_addr0");
        drive(1'b1, 1, 1, "w16_addr1");
        drive(1'b1, 1, 2, "w16_addr2");
        drive(1'b1, 1, 3, "w16_addr3");
        for (int k = 0; k < 4; k++) drive(1'b1, 2, k, "w8_lane");
        for (int k = 0; k < 4; k++) drive(1'b1, 3, k, "rsvd");
        drive(1'b1, 0, 1, "rsvd_to_w32");

        // reset in the middle of a changing stream
        drive(1'b1, 2, 3, "pre_rst");
        drive(1'b0, 2, 1, "mid_rst");
        drive(1'b1, 1, 1, "post_rst");
        drive(1'b1, 2, 2, "post_rst2");

        // random stream with occasional resets
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 15) != 0);
            c = $urandom_range(0, 3);
            a = $urandom_range(0, 3);
            drive(r, c, a, "random");
        end

        // drain
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
